// File: rtl/flash_mem_arbiter_pkg.sv
// Shared definitions for the two-port SPI-flash read arbiter.
// Holds the FSM state encoding and the data word returned on a watchdog completion.
package flash_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2,
      ST_DONE   = 2'd3
   } arb_state_e;

   localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/flash_mem_arbiter_wdog.sv
// Transaction watchdog: down-counter loaded on grant, expiry strobe at terminal count.
// The strobe fires on the TIMEOUT-th cycle the arbiter spends in a grant state.
module flash_arb_wdog #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic resetn,
   input  logic start,
   input  logic active,
   output logic expired
);

   localparam int               CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = CNT_LOAD;
      end else if (!active) begin
         cnt_d = '0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = active && (cnt_q == '0);

endmodule

// File: rtl/flash_mem_arbiter.sv
// Two-port read arbiter in front of spimemio: port 0 has priority, port 1 is
// guaranteed a slot after MAX_BURST port-0 grants, hung reads are completed by a watchdog.
//
// state     | meaning
// ST_IDLE   | choose a requester, register its address, raise flash_valid next cycle
// ST_GRANT0 | flash read in flight for port 0, waiting for flash_ready or watchdog
// ST_GRANT1 | flash read in flight for port 1, waiting for flash_ready or watchdog
// ST_DONE   | one idle cycle after a completion so the requester can drop valid
module flash_mem_arbiter
   import flash_mem_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int TIMEOUT   = 1024,
   parameter int ADDR_W    = 24
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              m0_valid,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic              m0_ready,
   output logic [31:0]       m0_rdata,
   input  logic              m1_valid,
   input  logic [ADDR_W-1:0] m1_addr,
   output logic              m1_ready,
   output logic [31:0]       m1_rdata,
   output logic              flash_valid,
   output logic [ADDR_W-1:0] flash_addr,
   input  logic              flash_ready,
   input  logic [31:0]       flash_rdata,
   output logic              timeout_err
);

   localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
   localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

   arb_state_e        state_q, state_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic              flash_valid_q, flash_valid_d;
   logic [ADDR_W-1:0] flash_addr_q, flash_addr_d;
   logic              m0_ready_q, m0_ready_d;
   logic              m1_ready_q, m1_ready_d;
   logic [31:0]       m0_rdata_q, m0_rdata_d;
   logic [31:0]       m1_rdata_q, m1_rdata_d;
   logic              timeout_err_q, timeout_err_d;
   logic [31:0]       done_data;
   logic              wdog_start;
   logic              wdog_active;
   logic              wdog_expired;

   assign wdog_active = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);

   flash_arb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .resetn  (resetn),
      .start   (wdog_start),
      .active  (wdog_active),
      .expired (wdog_expired)
   );

   always_comb begin
      state_d       = state_q;
      burst_d       = burst_q;
      flash_valid_d = flash_valid_q;
      flash_addr_d  = flash_addr_q;
      m0_ready_d    = 1'b0;
      m1_ready_d    = 1'b0;
      m0_rdata_d    = m0_rdata_q;
      m1_rdata_d    = m1_rdata_q;
      timeout_err_d = timeout_err_q;
      wdog_start    = 1'b0;
      done_data     = flash_ready ? flash_rdata : TIMEOUT_DATA;

      case (state_q)
         ST_IDLE: begin
            if (m1_valid && (!m0_valid || burst_q == BURST_MAX)) begin
               state_d       = ST_GRANT1;
               flash_addr_d  = m1_addr;
               flash_valid_d = 1'b1;
               burst_d       = '0;
               wdog_start    = 1'b1;
            end else if (m0_valid) begin
               state_d       = ST_GRANT0;
               flash_addr_d  = m0_addr;
               flash_valid_d = 1'b1;
               wdog_start    = 1'b1;
               // only grants that made port 1 wait count toward its guaranteed slot
               if (!m1_valid) begin
                  burst_d = '0;
               end else if (burst_q != BURST_MAX) begin
                  burst_d = burst_q + BURST_ONE;
               end
            end else begin
               burst_d = '0;
            end
         end
         ST_GRANT0, ST_GRANT1: begin
            // a real completion on the expiry cycle takes precedence over the watchdog
            if (flash_ready || wdog_expired) begin
               state_d       = ST_DONE;
               flash_valid_d = 1'b0;
               if (!flash_ready) begin
                  timeout_err_d = 1'b1;
               end
               if (state_q == ST_GRANT0) begin
                  m0_ready_d = 1'b1;
                  m0_rdata_d = done_data;
               end else begin
                  m1_ready_d = 1'b1;
                  m1_rdata_d = done_data;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         burst_q       <= '0;
         flash_valid_q <= 1'b0;
         flash_addr_q  <= '0;
         m0_ready_q    <= 1'b0;
         m1_ready_q    <= 1'b0;
         m0_rdata_q    <= '0;
         m1_rdata_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         burst_q       <= burst_d;
         flash_valid_q <= flash_valid_d;
         flash_addr_q  <= flash_addr_d;
         m0_ready_q    <= m0_ready_d;
         m1_ready_q    <= m1_ready_d;
         m0_rdata_q    <= m0_rdata_d;
         m1_rdata_q    <= m1_rdata_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign flash_valid = flash_valid_q;
   assign flash_addr  = flash_addr_q;
   assign m0_ready    = m0_ready_q;
   assign m1_ready    = m1_ready_q;
   assign m0_rdata    = m0_rdata_q;
   assign m1_rdata    = m1_rdata_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_flash_mem_arbiter.sv
// Bench for flash_mem_arbiter: directed scenarios followed by randomized request traffic,
// checked against a transaction-level model of the arbitration and completion rules.
module tb_flash_mem_arbiter;

   localparam int MAX_BURST = 4;
   localparam int TIMEOUT   = 1024;
   localparam int ADDR_W    = 24;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              m0_valid = 1'b0;
   logic [ADDR_W-1:0] m0_addr = '0;
   logic              m0_ready;
   logic [31:0]       m0_rdata;
   logic              m1_valid = 1'b0;
   logic [ADDR_W-1:0] m1_addr = '0;
   logic              m1_ready;
   logic [31:0]       m1_rdata;
   logic              flash_valid;
   logic [ADDR_W-1:0] flash_addr;
   logic              flash_ready = 1'b0;
   logic [31:0]       flash_rdata = '0;
   logic              timeout_err;

   int          n_cmp = 0;
   int          n_err = 0;
   int          streak = 0;
   logic [31:0] erd0 = '0;
   logic [31:0] erd1 = '0;
   logic        terr = 1'b0;

   always #5 clk = ~clk;

   flash_mem_arbiter #(
      .MAX_BURST (MAX_BURST),
      .TIMEOUT   (TIMEOUT),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .m0_valid    (m0_valid),
      .m0_addr     (m0_addr),
      .m0_ready    (m0_ready),
      .m0_rdata    (m0_rdata),
      .m1_valid    (m1_valid),
      .m1_addr     (m1_addr),
      .m1_ready    (m1_ready),
      .m1_rdata    (m1_rdata),
      .flash_valid (flash_valid),
      .flash_addr  (flash_addr),
      .flash_ready (flash_ready),
      .flash_rdata (flash_rdata),
      .timeout_err (timeout_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      logic [31:0] r;
      r = $urandom;
      return {r[ADDR_W-1:2], 2'b00};
   endfunction

   // Port 1 is owed the slot once port 0 has been served MAX_BURST times while it waited.
   function automatic int predict();
      int w;
      w = (m1_valid && (!m0_valid || streak == MAX_BURST)) ? 1 : 0;
      if (w == 1 || !m1_valid) streak = 0;
      else if (streak < MAX_BURST) streak++;
      return w;
   endfunction

   task automatic grant_checks(input int win);
      chk("grant_valid", 32'(flash_valid), 32'd1);
      chk("grant_addr", 32'(flash_addr), 32'((win == 1) ? m1_addr : m0_addr));
   endtask

   task automatic issue_from_idle(output int win);
      win = predict();
      step();
      grant_checks(win);
   endtask

   task automatic issue(output int win, input bit junk);
      win = predict();
      if (junk) begin
         flash_ready = 1'b1;
         flash_rdata = $urandom;
      end
      step();
      chk("idle_valid", 32'(flash_valid), 32'd0);
      chk("idle_ready0", 32'(m0_ready), 32'd0);
      chk("idle_ready1", 32'(m1_ready), 32'd0);
      step();
      flash_ready = 1'b0;
      grant_checks(win);
   endtask

   task automatic finish(input int win, input int lat, input logic [31:0] data, input bit drop);
      bit          exp_to;
      logic [31:0] exp_d;
      if (drop) begin
         if (win == 1) m1_valid = 1'b0;
         else m0_valid = 1'b0;
      end
      exp_to = (lat > TIMEOUT - 1);
      for (int k = 0; k < TIMEOUT; k++) begin
         if (flash_valid !== 1'b1) begin
            chk("hold_valid", 32'(flash_valid), 32'd1);
            break;
         end
         if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
            chk("early_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
            break;
         end
         if (k == lat) begin
            flash_ready = 1'b1;
            flash_rdata = data;
         end
         step();
         flash_ready = 1'b0;
         flash_rdata = $urandom;
         if (k == lat || k == TIMEOUT - 1) break;
      end
      exp_d = exp_to ? 32'hFFFF_FFFF : data;
      if (exp_to) terr = 1'b1;
      if (win == 1) erd1 = exp_d;
      else erd0 = exp_d;
      chk("done_valid", 32'(flash_valid), 32'd0);
      chk("done_ready0", 32'(m0_ready), (win == 0) ? 32'd1 : 32'd0);
      chk("done_ready1", 32'(m1_ready), (win == 1) ? 32'd1 : 32'd0);
      chk("rdata0", m0_rdata, erd0);
      chk("rdata1", m1_rdata, erd1);
      chk("timeout_err", 32'(timeout_err), 32'(terr));
   endtask

   task automatic rand_reqs(input int win);
      if (win == 0) begin
         if ($urandom_range(0, 3) == 0) m0_valid = 1'b0;
         else begin
            m0_valid = 1'b1;
            m0_addr  = rand_addr();
         end
         if (!m1_valid && $urandom_range(0, 1) == 1) begin
            m1_valid = 1'b1;
            m1_addr  = rand_addr();
         end
      end else begin
         if ($urandom_range(0, 3) == 0) m1_valid = 1'b0;
         else begin
            m1_valid = 1'b1;
            m1_addr  = rand_addr();
         end
         if (!m0_valid && $urandom_range(0, 1) == 1) begin
            m0_valid = 1'b1;
            m0_addr  = rand_addr();
         end
      end
      if (!m0_valid && !m1_valid) begin
         m0_valid = 1'b1;
         m0_addr  = rand_addr();
      end
   endtask

   initial begin
      int win;
      int obs;
      int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

      // reset held with both requesters active
      m0_valid = 1'b1;
      m0_addr  = 24'h000040;
      m1_valid = 1'b1;
      m1_addr  = 24'h100000;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_valid", 32'(flash_valid), 32'd0);
         chk("rst_ready0", 32'(m0_ready), 32'd0);
         chk("rst_ready1", 32'(m1_ready), 32'd0);
         chk("rst_terr", 32'(timeout_err), 32'd0);
      end
      chk("rst_addr", 32'(flash_addr), 32'd0);
      chk("rst_rdata0", m0_rdata, 32'd0);
      chk("rst_rdata1", m1_rdata, 32'd0);
      resetn = 1'b1;
      #1;
      chk("rel_valid", 32'(flash_valid), 32'd0);
      issue_from_idle(win);
      finish(win, 2, 32'h1234_5678, 1'b0);

      // lone port-1 read
      m0_valid = 1'b0;
      issue(win, 1'b0);
      finish(win, 8, 32'hDEAD_BEEF, 1'b0);

      // both ports saturating the flash
      m0_valid = 1'b1;
      m0_addr  = 24'h000200;
      for (int i = 0; i < 10; i++) begin
         issue(win, 1'b0);
         obs = (flash_addr === m1_addr) ? 1 : 0;
         chk("burst_order", 32'(obs), 32'(exp_order[i]));
         finish(win, int'($urandom_range(0, 4)), $urandom, 1'b0);
      end

      // completion on the expiry cycle is a normal one
      m0_valid = 1'b0;
      m1_addr  = 24'h0F0F00;
      issue(win, 1'b0);
      finish(win, TIMEOUT - 1, 32'hA5A5_5A5A, 1'b0);

      // hung read forced complete, then normal traffic with the error sticky
      m0_valid = 1'b1;
      m0_addr  = 24'h003000;
      m1_valid = 1'b0;
      issue(win, 1'b0);
      finish(win, 5000, 32'h0BAD_0BAD, 1'b0);
      issue(win, 1'b0);
      finish(win, 3, 32'h600D_600D, 1'b0);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         rand_reqs(win);
         issue(win, ($urandom_range(0, 3) == 0));
         finish(win, int'($urandom_range(0, 6)), $urandom, ($urandom_range(0, 7) == 0));
      end

      // reset in the middle of a port-1 read
      m0_valid = 1'b0;
      m1_valid = 1'b1;
      m1_addr  = 24'h0ABCD0;
      issue(win, 1'b0);
      step();
      step();
      resetn = 1'b0;
      #1;
      chk("arst_valid", 32'(flash_valid), 32'd0);
      chk("arst_ready1", 32'(m1_ready), 32'd0);
      flash_ready = 1'b1;
      flash_rdata = 32'h1111_2222;
      step();
      chk("arst_hold_valid", 32'(flash_valid), 32'd0);
      chk("arst_hold_ready1", 32'(m1_ready), 32'd0);
      chk("arst_terr", 32'(timeout_err), 32'd0);
      chk("arst_rdata1", m1_rdata, 32'd0);
      step();
      flash_ready = 1'b0;
      resetn = 1'b1;
      streak = 0;
      erd0 = '0;
      erd1 = '0;
      terr = 1'b0;
      chk("arst_rel_ready1", 32'(m1_ready), 32'd0);
      issue_from_idle(win);
      finish(win, 3, 32'hCAFE_F00D, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
